// File: rtl/power_uart_link.sv
// -----------------------------------------------------------------------------
// power_uart_link
//   Single-clock 8N1 UART command transceiver for the power-control serial
//   link. Received frames are HDR, RX_BYTES payload bytes (MSB byte first) and
//   an XOR checksum. A good frame updates rx_data. A bad frame is dropped and
//   reported on rx_err. A frame is dropped on a checksum mismatch, on a
//   framing error, or when the gap between bytes exceeds TIMEOUT_CLKS.
//   Transmitted frames use the same format with TX_BYTES payload bytes.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   uart_rx  serial input (asynchronous, idle high)
//   uart_tx  serial output (idle high)
//   rx_data  last good received payload, first byte in the MSBs
//   rx_vld   one-cycle pulse when rx_data is updated
//   rx_err   one-cycle pulse when a received frame is dropped
//   send_en  transmit request, accepted only while tx_busy is low
//   tx_data  payload to transmit, MSB byte sent first
//   tx_busy  high while a frame is on the wire
// -----------------------------------------------------------------------------
module power_uart_link #(
  parameter int          BAUD_DIV     = 434,
  parameter int          RX_BYTES     = 5,
  parameter int          TX_BYTES     = 4,
  parameter logic [7:0]  HDR          = 8'hA5,
  parameter int          TIMEOUT_CLKS = 2*11*BAUD_DIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic [8*RX_BYTES-1:0] rx_data,
  output logic                  rx_vld,
  output logic                  rx_err,
  input  logic                  send_en,
  input  logic [8*TX_BYTES-1:0] tx_data,
  output logic                  tx_busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(RX_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int BW = $clog2(TX_BYTES + 2);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV/2 - 1);
  localparam logic [PW-1:0] PAY_LAST  = PW'(RX_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [BW-1:0] CSUM_PREV = BW'(TX_BYTES);
  localparam logic [BW-1:0] LAST_BYTE = BW'(TX_BYTES + 1);

  function automatic logic [7:0] xor_bytes(input logic [8*TX_BYTES-1:0] d);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < TX_BYTES; i++) x = x ^ d[8*i +: 8];
    return x;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchroniser: p0/p1 form the 2-flop synchroniser, p2 is the previous
  // synchronised value used for falling-edge detection.
  // ---------------------------------------------------------------------------
  logic rx_sync_p0, rx_sync_p1, rx_sync_p2;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_sync_p2 <= 1'b1;
    end else begin
      rx_sync_p0 <= uart_rx;
      rx_sync_p1 <= rx_sync_p0;
      rx_sync_p2 <= rx_sync_p1;
    end
  end

  assign rx_fall = rx_sync_p2 & ~rx_sync_p1;

  // ---------------------------------------------------------------------------
  // RX bit engine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RB_IDLE, RB_START, RB_DATA, RB_STOP} rb_state_t;

  rb_state_t     rb_state, rb_nxt;
  logic [CW-1:0] rb_cnt;
  logic [2:0]    rb_bit;
  logic [7:0]    rb_shift;
  logic          rb_tick, rb_sample, stb_set, ferr_set;
  logic          byte_stb, frm_err;

  always_comb begin
    rb_nxt    = rb_state;
    rb_sample = 1'b0;
    stb_set   = 1'b0;
    ferr_set  = 1'b0;
    // Start bit is sampled half a bit in; later samples are one bit apart.
    rb_tick   = (rb_state == RB_START) ? (rb_cnt == HALF_LAST) : (rb_cnt == BIT_LAST);
    case (rb_state)
      RB_IDLE:  if (rx_fall) rb_nxt = RB_START;
      RB_START: if (rb_tick) rb_nxt = rx_sync_p1 ? RB_IDLE : RB_DATA;
      RB_DATA: begin
        if (rb_tick) begin
          rb_sample = 1'b1;
          if (rb_bit == 3'd7) rb_nxt = RB_STOP;
        end
      end
      RB_STOP: begin
        if (rb_tick) begin
          rb_nxt   = RB_IDLE;
          stb_set  = rx_sync_p1;
          ferr_set = ~rx_sync_p1;
        end
      end
      default: rb_nxt = RB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_state <= RB_IDLE;
      rb_cnt   <= '0;
      rb_bit   <= '0;
      byte_stb <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rb_state <= rb_nxt;
      if (rb_state == RB_IDLE || rb_tick) rb_cnt <= '0;
      else                                rb_cnt <= rb_cnt + 1'b1;
      if (rb_state != RB_DATA) rb_bit <= '0;
      else if (rb_sample)      rb_bit <= rb_bit + 1'b1;
      byte_stb <= stb_set;
      frm_err  <= ferr_set;
    end
  end

  // LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (rb_sample) rb_shift <= {rx_sync_p1, rb_shift[7:1]};
  end

  // ---------------------------------------------------------------------------
  // RX frame FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {WAIT_HDR, PAYLOAD, CHECK} fs_state_t;

  fs_state_t             fs_state, fs_nxt;
  logic [PW-1:0]         pay_cnt;
  logic [TW-1:0]         idle_cnt;
  logic [7:0]            rx_xor;
  logic [8*RX_BYTES-1:0] staging;
  logic                  timeout, hdr_seen, take_pay, vld_set, err_set;

  assign timeout = (idle_cnt == TO_LAST);

  always_comb begin
    fs_nxt   = fs_state;
    hdr_seen = 1'b0;
    take_pay = 1'b0;
    vld_set  = 1'b0;
    err_set  = 1'b0;
    case (fs_state)
      WAIT_HDR: begin
        if (byte_stb && rb_shift == HDR) begin
          hdr_seen = 1'b1;
          fs_nxt   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (frm_err) begin
          err_set = 1'b1;
          fs_nxt  = WAIT_HDR;
        end else if (byte_stb) begin
          take_pay = 1'b1;
          if (pay_cnt == PAY_LAST) fs_nxt = CHECK;
        end else if (timeout) begin
          err_set = 1'b1;
          fs_nxt  = WAIT_HDR;
        end
      end
      CHECK: begin
        if (frm_err) begin
          err_set = 1'b1;
          fs_nxt  = WAIT_HDR;
        end else if (byte_stb) begin
          vld_set = (rb_shift == rx_xor);
          err_set = (rb_shift != rx_xor);
          fs_nxt  = WAIT_HDR;
        end else if (timeout) begin
          err_set = 1'b1;
          fs_nxt  = WAIT_HDR;
        end
      end
      default: fs_nxt = WAIT_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_state <= WAIT_HDR;
      pay_cnt  <= '0;
      idle_cnt <= '0;
      rx_vld   <= 1'b0;
      rx_err   <= 1'b0;
      rx_data  <= '0;
    end else begin
      fs_state <= fs_nxt;
      if (hdr_seen)      pay_cnt <= '0;
      else if (take_pay) pay_cnt <= pay_cnt + 1'b1;
      if (fs_state == WAIT_HDR || byte_stb) idle_cnt <= '0;
      else if (!timeout)                    idle_cnt <= idle_cnt + 1'b1;
      rx_vld <= vld_set;
      rx_err <= err_set;
      if (vld_set) rx_data <= staging;
    end
  end

  // First payload byte ends up in the MSBs after RX_BYTES shifts.
  always_ff @(posedge clk) begin
    if (hdr_seen) rx_xor <= 8'h00;
    else if (take_pay) begin
      rx_xor  <= rx_xor ^ rb_shift;
      staging <= (staging << 8) | (8*RX_BYTES)'(rb_shift);
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} tx_state_t;

  tx_state_t             tx_state, tx_nxt;
  logic [CW-1:0]         tx_cnt;
  logic [3:0]            tx_bit;
  logic [BW-1:0]         tx_idx;
  logic [8*TX_BYTES-1:0] tx_buf;
  logic [7:0]            tx_csum;
  logic [9:0]            tx_shift;
  logic                  accept, bit_end, byte_end, frame_end;

  assign bit_end   = (tx_state == TX_SEND) && (tx_cnt == BIT_LAST);
  assign byte_end  = bit_end && (tx_bit == 4'd9);
  assign frame_end = byte_end && (tx_idx == LAST_BYTE);

  // DONE is the single idle cycle after the last stop bit; it accepts a new
  // request exactly like IDLE.
  always_comb begin
    tx_nxt = tx_state;
    accept = 1'b0;
    case (tx_state)
      TX_IDLE, TX_DONE: begin
        if (send_en) begin
          accept = 1'b1;
          tx_nxt = TX_SEND;
        end else begin
          tx_nxt = TX_IDLE;
        end
      end
      TX_SEND: if (frame_end) tx_nxt = TX_DONE;
      default: tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_idx   <= '0;
    end else begin
      tx_state <= tx_nxt;
      if (tx_state != TX_SEND || bit_end) tx_cnt <= '0;
      else                                tx_cnt <= tx_cnt + 1'b1;
      if (accept)       tx_bit <= '0;
      else if (bit_end) tx_bit <= byte_end ? 4'd0 : tx_bit + 4'd1;
      if (accept)                     tx_idx <= '0;
      else if (byte_end && !frame_end) tx_idx <= tx_idx + 1'b1;
    end
  end

  // tx_shift holds the current byte as {stop, data, start}; bit 0 is on the wire.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_buf   <= tx_data;
      tx_csum  <= xor_bytes(tx_data);
      tx_shift <= {1'b1, HDR, 1'b0};
    end else if (bit_end) begin
      if (byte_end) begin
        if (tx_idx == CSUM_PREV) begin
          tx_shift <= {1'b1, tx_csum, 1'b0};
        end else begin
          tx_shift <= {1'b1, tx_buf[8*TX_BYTES-1 -: 8], 1'b0};
          tx_buf   <= tx_buf << 8;
        end
      end else begin
        tx_shift <= {1'b1, tx_shift[9:1]};
      end
    end
  end

  assign tx_busy = (tx_state == TX_SEND);
  assign uart_tx = tx_busy ? tx_shift[0] : 1'b1;

endmodule

// File: tb/tb_power_uart_link.sv
// -----------------------------------------------------------------------------
// tb_power_uart_link
//   Directed bench for power_uart_link. dut drives/receives 5-byte RX frames
//   and sends 4-byte TX frames. dut_lb has its uart_tx looped back to uart_rx
//   with 4-byte frames both ways. Expected pulses and bytes are queued as the
//   stimulus is driven and popped by monitors when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_power_uart_link;

  localparam int BAUD = 8;

  typedef struct packed {
    logic        err;
    logic [39:0] data;
  } ev_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } ev_lb_t;

  logic        clk = 1'b0;
  logic        rst_n, rst_lb_n;
  logic        uart_rx, uart_tx;
  logic [39:0] rx_data;
  logic        rx_vld, rx_err;
  logic        send_en;
  logic [31:0] tx_data;
  logic        tx_busy;

  logic        uart_tx_lb;
  logic [31:0] rx_data_lb;
  logic        rx_vld_lb, rx_err_lb;
  logic        send_en_lb;
  logic [31:0] tx_data_lb;
  logic        tx_busy_lb;

  int checks = 0;
  int errors = 0;

  ev_t        exp_q[$];
  ev_lb_t     lb_q[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  power_uart_link #(.BAUD_DIV(BAUD), .RX_BYTES(5), .TX_BYTES(4), .HDR(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_err(rx_err),
    .send_en(send_en), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  power_uart_link #(.BAUD_DIV(BAUD), .RX_BYTES(4), .TX_BYTES(4), .HDR(8'hA5)) dut_lb (
    .clk(clk), .rst_n(rst_lb_n), .uart_rx(uart_tx_lb), .uart_tx(uart_tx_lb),
    .rx_data(rx_data_lb), .rx_vld(rx_vld_lb), .rx_err(rx_err_lb),
    .send_en(send_en_lb), .tx_data(tx_data_lb), .tx_busy(tx_busy_lb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BAUD) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i], 1'b1);
  endtask

  task automatic wait_drain(input int max_cycles, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_drain_lb(input int max_cycles, input string tag);
    int n = 0;
    while (lb_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk(tag, lb_q.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  // RX pulse monitor for dut
  always @(negedge clk) begin : rx_mon
    ev_t e;
    if (rx_vld || rx_err) begin
      chk("rx_vld_err_exclusive", rx_vld & rx_err, 0);
      if (exp_q.size() == 0) begin
        chk("rx_unexpected_pulse", {rx_err, rx_vld}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("rx_pulse_kind", {rx_err, rx_vld}, e.err ? 2'b10 : 2'b01);
        chk("rx_data", rx_data, e.data);
      end
    end
  end

  // RX pulse monitor for dut_lb
  always @(negedge clk) begin : lb_mon
    ev_lb_t e;
    if (rx_vld_lb || rx_err_lb) begin
      if (lb_q.size() == 0) begin
        chk("lb_unexpected_pulse", {rx_err_lb, rx_vld_lb}, 2'b00);
      end else begin
        e = lb_q.pop_front();
        chk("lb_pulse_kind", {rx_err_lb, rx_vld_lb}, e.err ? 2'b10 : 2'b01);
        chk("lb_rx_data", rx_data_lb, e.data);
      end
    end
  end

  // Independent UART decoder on dut.uart_tx
  initial begin : tx_decoder
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        repeat (BAUD/2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (BAUD) @(negedge clk);
        chk("tx_stop_bit", uart_tx, 1'b1);
        chk("tx_byte_expected", tx_q.size() != 0, 1'b1);
        if (tx_q.size() != 0) chk("tx_byte", b, tx_q.pop_front());
      end
    end
  end

  initial begin : stim
    int cnt;
    rst_n      = 1'b0;
    rst_lb_n   = 1'b0;
    uart_rx    = 1'b1;
    send_en    = 1'b0;
    tx_data    = '0;
    send_en_lb = 1'b0;
    tx_data_lb = '0;
    repeat (3) @(negedge clk);

    chk("reset_uart_tx", uart_tx, 1'b1);
    chk("reset_rx_data", rx_data, 40'h0);
    chk("reset_rx_vld", rx_vld, 1'b0);
    chk("reset_rx_err", rx_err, 1'b0);
    chk("reset_tx_busy", tx_busy, 1'b0);

    rst_n    = 1'b1;
    rst_lb_n = 1'b1;
    repeat (4) @(negedge clk);

    // Good frame
    exp_q.push_back('{err: 1'b0, data: 40'h1122334455});
    send_frame('{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h11});
    wait_drain(200, "good_frame_drain");
    chk("rx_data_after_good", rx_data, 40'h1122334455);

    // Bad checksum: error, data held
    exp_q.push_back('{err: 1'b1, data: 40'h1122334455});
    send_frame('{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h12});
    wait_drain(200, "bad_csum_drain");
    chk("rx_data_after_bad_csum", rx_data, 40'h1122334455);

    // Leading junk ignored, partial frame times out
    exp_q.push_back('{err: 1'b1, data: 40'h1122334455});
    send_frame('{8'h00, 8'h7E, 8'hA5, 8'h11, 8'h22});
    wait_drain(400, "timeout_drain");

    // Following valid frame
    exp_q.push_back('{err: 1'b0, data: 40'h0102030405});
    send_frame('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01});
    wait_drain(200, "after_timeout_drain");

    // Framing error on second payload byte
    exp_q.push_back('{err: 1'b1, data: 40'h0102030405});
    send_frame('{8'hA5, 8'h11});
    send_byte(8'h22, 1'b0);
    repeat (2*BAUD) @(negedge clk);
    wait_drain(200, "framing_err_drain");

    // One bit-time low glitch while idle
    uart_rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30*BAUD) @(negedge clk);
    chk("glitch_no_event", exp_q.size(), 0);
    chk("rx_data_after_glitch", rx_data, 40'h0102030405);

    exp_q.push_back('{err: 1'b0, data: 40'hAABBCCDDEE});
    send_frame('{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hEE});
    wait_drain(200, "after_glitch_drain");

    // TX frame
    tx_data = 32'hDEADBEEF;
    send_en = 1'b1;
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'hDE);
    tx_q.push_back(8'hAD);
    tx_q.push_back(8'hBE);
    tx_q.push_back(8'hEF);
    tx_q.push_back(8'h22);
    @(negedge clk);
    send_en = 1'b0;
    chk("tx_busy_rise", tx_busy, 1'b1);
    chk("tx_start_same_cycle", uart_tx, 1'b0);
    cnt = 0;
    while (tx_busy === 1'b1 && cnt < 1000) begin
      cnt++;
      if (cnt == 100) tx_data = 32'h12345678;
      send_en = (cnt == 200);
      @(negedge clk);
    end
    send_en = 1'b0;
    chk("tx_busy_cycles", cnt, 480);
    repeat (100) @(negedge clk);
    chk("tx_all_bytes_seen", tx_q.size(), 0);
    chk("tx_idle_high", uart_tx, 1'b1);
    chk("tx_idle_not_busy", tx_busy, 1'b0);

    // Loopback with reset mid-transmission
    tx_data_lb = 32'h01020304;
    send_en_lb = 1'b1;
    @(negedge clk);
    send_en_lb = 1'b0;
    repeat (150) @(negedge clk);
    rst_lb_n = 1'b0;
    #1;
    chk("lb_reset_uart_tx", uart_tx_lb, 1'b1);
    chk("lb_reset_tx_busy", tx_busy_lb, 1'b0);
    repeat (3) @(negedge clk);
    rst_lb_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("lb_no_event_after_reset", lb_q.size(), 0);

    lb_q.push_back('{err: 1'b0, data: 32'hCAFEF00D});
    tx_data_lb = 32'hCAFEF00D;
    send_en_lb = 1'b1;
    @(negedge clk);
    send_en_lb = 1'b0;
    wait_drain_lb(700, "lb_frame_drain");
    chk("lb_rx_data_final", rx_data_lb, 32'hCAFEF00D);

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
